// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus independent per-bit debounce counters for the board slide switches.
// Produces a stable switch word, registered rise/fall/change pulses and an LED copy of the stable word.
module sw_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic [WIDTH-1:0] led
);

    localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_TERMINAL = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // A bit's counter only runs while the synchronised level disagrees with the accepted level,
    // so any agreement (a bounce back) restarts qualification from zero.
    always_comb begin
        stable_nxt = sw_stable;
        rise_nxt   = '0;
        fall_nxt   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_TERMINAL) begin
                    stable_nxt[i] = sync2[i];
                    rise_nxt[i]   = sync2[i];
                    fall_nxt[i]   = ~sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            sw_rise    <= '0;
            sw_fall    <= '0;
            sw_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1      <= sw;
            sync2      <= sync1;
            sw_stable  <= stable_nxt;
            sw_rise    <= rise_nxt;
            sw_fall    <= fall_nxt;
            sw_changed <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign led = sw_stable;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce: a window-based reference model fills a scoreboard
// queue that an independent monitor drains once per clock.
module tb_sw_debounce;

    localparam int W = 16;
    localparam int D = 4;

    typedef struct packed {
        logic [W-1:0] st;
        logic [W-1:0] ri;
        logic [W-1:0] fa;
        logic         ch;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
    logic [W-1:0] led;

    int tests        = 0;
    int failures     = 0;
    int changedCount = 0;
    int cycleNum     = 0;

    exp_t         expQ[$];
    logic [W-1:0] delayQ[$];
    logic [W-1:0] window[$];
    logic [W-1:0] mStable = '0;
    logic [W-1:0] curSw   = '0;

    sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .sw_stable (sw_stable),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed),
        .led       (led)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model: a bit is accepted once the last D values reaching the compare point (two edges behind sw) all oppose it.
    task automatic modelStep(input logic r, input logic [W-1:0] s);
        exp_t         e;
        logic [W-1:0] c;
        logic [W-1:0] oldStable;
        logic         allOpp;
        if (r) begin
            mStable = '0;
            delayQ.delete();
            delayQ.push_back('0);
            delayQ.push_back('0);
            window.delete();
            e = '0;
        end else begin
            c = delayQ.pop_front();
            delayQ.push_back(s);
            window.push_back(c);
            if (window.size() > D) void'(window.pop_front());
            oldStable = mStable;
            for (int b = 0; b < W; b++) begin
                allOpp = (window.size() == D);
                foreach (window[k]) if (window[k][b] == oldStable[b]) allOpp = 1'b0;
                if (allOpp) mStable[b] = ~oldStable[b];
            end
            e.st = mStable;
            e.ri = mStable & ~oldStable;
            e.fa = ~mStable & oldStable;
            e.ch = (e.ri | e.fa) != '0;
        end
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic r, input logic [W-1:0] s);
        @(negedge clk);
        rst   = r;
        sw    = s;
        curSw = s;
        modelStep(r, s);
    endtask

    task automatic hold(input logic [W-1:0] s, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, s);
    endtask

    task automatic checkChanged(input string name, input int expected);
        checkOutput(name, 80'(changedCount), 80'(expected));
        changedCount = 0;
    endtask

    // Monitor: every edge that has a scoreboard entry is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycleNum++;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                if (sw_changed === 1'b1) changedCount++;
                checkOutput($sformatf("stable/rise/fall/changed @%0d", cycleNum),
                            80'({sw_stable, sw_rise, sw_fall, sw_changed}), 80'({e.st, e.ri, e.fa, e.ch}));
                checkOutput($sformatf("led @%0d", cycleNum), 80'(led), 80'(e.st));
            end
        end
    end

    initial begin
        logic [W-1:0] r;
        $display("[TB] starting sw_debounce bench, DEBOUNCE_CYCLES=%0d", D);

        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'hFFFF);
        hold(16'hFFFF, 9);
        checkChanged("power-up rise count", 1);
        hold(16'h0000, 9);
        changedCount = 0;

        hold(16'h0008, 9);
        hold(16'h0000, 9);
        checkChanged("sw3 toggle pulse count", 2);

        hold(16'h0001, 3);
        hold(16'h0000, 9);
        checkChanged("short bounce pulse count", 0);

        hold(16'h0001, 1);
        hold(16'h0000, 1);
        hold(16'h0001, 1);
        hold(16'h0000, 1);
        hold(16'h0001, 9);
        checkChanged("bounce then solid pulse count", 1);
        hold(16'h0000, 9);
        changedCount = 0;

        hold(16'h8001, 9);
        checkChanged("simultaneous rise pulse count", 1);
        hold(16'h0000, 9);
        changedCount = 0;

        hold(16'h0020, 2);
        applyStimulus(1'b1, 16'h0020);
        applyStimulus(1'b1, 16'h0020);
        hold(16'h0020, 9);
        checkChanged("reset mid-count pulse count", 1);
        hold(16'h0000, 9);

        for (int k = 0; k < 600; k++) begin
            r = curSw;
            if ($urandom_range(3) == 0) r = curSw ^ W'($urandom & $urandom & $urandom);
            applyStimulus($urandom_range(99) == 0, r);
        end
        hold(16'h0000, 10);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard drained", 80'(expQ.size()), 80'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
